// File: rtl/difftest_step_batcher.sv
// difftest_step_batcher
// Counts committed instructions on the DUT side of the difftest bridge and
// emits them in batches as `step` values for the simulation-side consumer.
// A nonzero deferred `simv_result` drains the outstanding count, latches
// the result code and parks the block in HALT until reset.
module difftest_step_batcher #(
  parameter int STEP_WIDTH = 8,
  parameter int CNT_WIDTH  = 4,
  parameter int BATCH      = 64,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  commit_valid,
  input  logic [CNT_WIDTH-1:0]  commit_cnt,
  input  logic                  flush,
  input  logic [7:0]            simv_result,
  output logic [STEP_WIDTH-1:0] step,
  output logic [STEP_WIDTH:0]   pending,
  output logic                  halted,
  output logic [7:0]            halt_code
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [STEP_WIDTH:0] STEP_MAX = {1'b0, {STEP_WIDTH{1'b1}}};
  localparam logic [STEP_WIDTH:0] BATCH_W  = (STEP_WIDTH+1)'(BATCH);
  localparam logic [TW-1:0]       TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t                state_r, state_next_s;
  logic [STEP_WIDTH:0]   acc_r, acc_next_s, acc_upd_s, add_s;
  logic [STEP_WIDTH-1:0] step_r, emit_val_s;
  logic [TW-1:0]         timer_r, timer_next_s;
  logic [7:0]            halt_code_r, code_next_s;
  logic                  halted_r;
  logic                  emit_s, acc_nz_s;

  // Next-state, emission decision and next values for accumulator and timer.
  always_comb begin
    state_next_s = state_r;
    code_next_s  = halt_code_r;
    emit_s       = 1'b0;
    add_s        = {(STEP_WIDTH+1){1'b0}};
    if ((state_r == ST_RUN) && commit_valid) begin
      add_s = {{(STEP_WIDTH+1-CNT_WIDTH){1'b0}}, commit_cnt};
    end else begin
      add_s = {(STEP_WIDTH+1){1'b0}};
    end
    acc_next_s = acc_r + add_s;
    acc_nz_s   = (acc_next_s != {(STEP_WIDTH+1){1'b0}});
    // Saturate the emitted value; the remainder stays in the accumulator.
    if (acc_next_s > STEP_MAX) begin
      emit_val_s = STEP_MAX[STEP_WIDTH-1:0];
    end else begin
      emit_val_s = acc_next_s[STEP_WIDTH-1:0];
    end
    case (state_r)
      ST_RUN: begin
        if (simv_result != 8'd0) begin
          // Stop request: this cycle's commits still count, flush what we have.
          state_next_s = ST_DRAIN;
          code_next_s  = simv_result;
          emit_s       = acc_nz_s;
        end else begin
          emit_s = acc_nz_s && ((acc_next_s >= BATCH_W) || flush ||
                                (timer_r == TIMER_LAST));
        end
      end
      ST_DRAIN: begin
        emit_s = acc_nz_s;
        if (acc_r == {(STEP_WIDTH+1){1'b0}}) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_HALT: begin
        emit_s       = 1'b0;
        state_next_s = ST_HALT;
      end
      default: begin
        emit_s       = 1'b0;
        state_next_s = ST_RUN;
      end
    endcase
    if (emit_s) begin
      acc_upd_s = acc_next_s - {1'b0, emit_val_s};
    end else begin
      acc_upd_s = acc_next_s;
    end
    // The idle timer only runs in RUN while something is waiting unemitted.
    if ((state_r != ST_RUN) || emit_s || !acc_nz_s) begin
      timer_next_s = {TW{1'b0}};
    end else begin
      timer_next_s = timer_r + TW'(1);
    end
  end

  // State, accumulator, timer and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_RUN;
      acc_r       <= {(STEP_WIDTH+1){1'b0}};
      timer_r     <= {TW{1'b0}};
      step_r      <= {STEP_WIDTH{1'b0}};
      halt_code_r <= 8'd0;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      acc_r       <= acc_upd_s;
      timer_r     <= timer_next_s;
      step_r      <= emit_s ? emit_val_s : {STEP_WIDTH{1'b0}};
      halt_code_r <= code_next_s;
      halted_r    <= (state_next_s == ST_HALT);
    end
  end

  assign step      = step_r;
  assign pending   = acc_r;
  assign halted    = halted_r;
  assign halt_code = halt_code_r;

endmodule

// File: tb/tb_difftest_step_batcher.sv
// Directed bench for difftest_step_batcher: one instance with 8-bit steps
// (BATCH 64) and one with 4-bit steps (BATCH 12) for the saturation cases.
module tb_difftest_step_batcher;

  logic       clock;
  logic       reset_n;
  logic       a_valid, a_flush;
  logic [3:0] a_cnt;
  logic [7:0] a_simv;
  logic [7:0] a_step;
  logic [8:0] a_pending;
  logic       a_halted;
  logic [7:0] a_code;
  logic       b_valid, b_flush;
  logic [3:0] b_cnt;
  logic [7:0] b_simv;
  logic [3:0] b_step;
  logic [4:0] b_pending;
  logic       b_halted;
  logic [7:0] b_code;

  int checks;
  int errors;
  int nz;

  difftest_step_batcher #(.STEP_WIDTH(8), .CNT_WIDTH(4), .BATCH(64), .TIMEOUT(16)) u_a (
    .clock(clock), .reset_n(reset_n), .commit_valid(a_valid), .commit_cnt(a_cnt),
    .flush(a_flush), .simv_result(a_simv), .step(a_step), .pending(a_pending),
    .halted(a_halted), .halt_code(a_code)
  );

  difftest_step_batcher #(.STEP_WIDTH(4), .CNT_WIDTH(4), .BATCH(12), .TIMEOUT(16)) u_b (
    .clock(clock), .reset_n(reset_n), .commit_valid(b_valid), .commit_cnt(b_cnt),
    .flush(b_flush), .simv_result(b_simv), .step(b_step), .pending(b_pending),
    .halted(b_halted), .halt_code(b_code)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; nz = 0;
    clock = 1'b0; reset_n = 1'b0;
    a_valid = 1'b0; a_flush = 1'b0; a_cnt = 4'd0; a_simv = 8'd0;
    b_valid = 1'b0; b_flush = 1'b0; b_cnt = 4'd0; b_simv = 8'd0;
    #2;
    check("reset_step", 32'(a_step), 32'd0);
    check("reset_pending", 32'(a_pending), 32'd0);
    check("reset_halted", 32'(a_halted), 32'd0);
    check("reset_code", 32'(a_code), 32'd0);
    #20 reset_n = 1'b1;
    tick();

    // Batch threshold: 16 x 4 commits
    a_valid = 1'b1; a_cnt = 4'd4;
    for (int i = 0; i < 15; i++) tick();
    check("batch_pre_pending", 32'(a_pending), 32'd60);
    check("batch_pre_step", 32'(a_step), 32'd0);
    tick();
    check("batch_step", 32'(a_step), 32'd64);
    check("batch_pending", 32'(a_pending), 32'd0);
    a_valid = 1'b0;
    tick();
    check("batch_after_step", 32'(a_step), 32'd0);

    // Timeout: single commit of 3, then idle
    a_valid = 1'b1; a_cnt = 4'd3;
    tick();
    a_valid = 1'b0;
    nz = 0;
    for (int i = 0; i < 14; i++) begin
      if (a_step != 8'd0) nz++;
      tick();
    end
    if (a_step != 8'd0) nz++;
    check("timeout_quiet", 32'(nz), 32'd0);
    tick();
    check("timeout_step", 32'(a_step), 32'd3);
    check("timeout_pending", 32'(a_pending), 32'd0);
    tick();
    check("timeout_after_step", 32'(a_step), 32'd0);

    // Flush
    a_valid = 1'b1; a_cnt = 4'd5;
    tick();
    check("flush_pre_pending", 32'(a_pending), 32'd5);
    a_cnt = 4'd2; a_flush = 1'b1;
    tick();
    a_valid = 1'b0; a_flush = 1'b0;
    check("flush_step", 32'(a_step), 32'd7);
    check("flush_pending", 32'(a_pending), 32'd0);

    // Saturation on the 4-bit instance
    b_valid = 1'b1; b_cnt = 4'd11;
    tick();
    check("sat_pre_pending", 32'(b_pending), 32'd11);
    check("sat_pre_step", 32'(b_step), 32'd0);
    b_cnt = 4'd15;
    tick();
    b_valid = 1'b0;
    check("sat_step", 32'(b_step), 32'd15);
    check("sat_pending", 32'(b_pending), 32'd11);
    nz = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (b_step != 4'd0) nz++;
    end
    check("sat_quiet", 32'(nz), 32'd0);
    tick();
    check("sat_timeout_step", 32'(b_step), 32'd11);
    check("sat_timeout_pending", 32'(b_pending), 32'd0);

    // Asynchronous reset mid-batch
    a_valid = 1'b1; a_cnt = 4'd15;
    tick();
    tick();
    a_valid = 1'b0;
    check("areset_pre_pending", 32'(a_pending), 32'd30);
    tick(); tick(); tick();
    #3 reset_n = 1'b0;
    #1;
    check("areset_pending", 32'(a_pending), 32'd0);
    check("areset_step", 32'(a_step), 32'd0);
    check("areset_halted", 32'(a_halted), 32'd0);
    #7 reset_n = 1'b1;
    tick();
    nz = 0;
    for (int i = 0; i < 20; i++) begin
      if ((a_step != 8'd0) || (a_pending != 9'd0)) nz++;
      tick();
    end
    check("areset_quiet", 32'(nz), 32'd0);

    // Halt drain
    a_valid = 1'b1; a_cnt = 4'd15;
    tick(); tick();
    a_cnt = 4'd10;
    tick();
    check("halt_pre_pending", 32'(a_pending), 32'd40);
    check("halt_pre_step", 32'(a_step), 32'd0);
    a_cnt = 4'd1; a_simv = 8'h02;
    tick();
    check("halt_drain_step", 32'(a_step), 32'd41);
    check("halt_drain_pending", 32'(a_pending), 32'd0);
    check("halt_drain_halted", 32'(a_halted), 32'd0);
    check("halt_drain_code", 32'(a_code), 32'd2);
    a_cnt = 4'd4; a_simv = 8'h05;
    tick();
    check("halt_step", 32'(a_step), 32'd0);
    check("halt_halted", 32'(a_halted), 32'd1);
    nz = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ((a_step != 8'd0) || (a_pending != 9'd0)) nz++;
    end
    check("halt_quiet", 32'(nz), 32'd0);
    check("halt_code_kept", 32'(a_code), 32'd2);
    check("halt_still", 32'(a_halted), 32'd1);

    // Drain with a saturated remainder on the 4-bit instance
    b_valid = 1'b1; b_cnt = 4'd11;
    tick();
    b_cnt = 4'd15; b_simv = 8'h01;
    tick();
    b_valid = 1'b0; b_simv = 8'h00;
    check("drain_first_step", 32'(b_step), 32'd15);
    check("drain_first_pending", 32'(b_pending), 32'd11);
    check("drain_first_halted", 32'(b_halted), 32'd0);
    check("drain_code", 32'(b_code), 32'd1);
    tick();
    check("drain_second_step", 32'(b_step), 32'd11);
    check("drain_second_pending", 32'(b_pending), 32'd0);
    check("drain_second_halted", 32'(b_halted), 32'd0);
    tick();
    check("drain_done_step", 32'(b_step), 32'd0);
    check("drain_done_halted", 32'(b_halted), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/difftest_step_batcher.md
# difftest_step_batcher

Transmit-side counterpart of the deferred-result control block. It sits on the DUT side of the difftest bridge and counts committed instructions each cycle. It batches those counts into `step` values for the simulation-side step consumer, which calls the software step routine whenever `step != 0`. It also watches the deferred `simv_result` coming back from software: on a nonzero result it drains the outstanding count, latches the result code and stops stepping.

## Interface
- `STEP_WIDTH`, default 8: width of `step`; `STEP_MAX = 2^STEP_WIDTH - 1`.
- `CNT_WIDTH`, default 4: width of the per-cycle commit count; must be ≤ `STEP_WIDTH`.
- `BATCH`, default 64: emission threshold; 1 ≤ `BATCH` ≤ `STEP_MAX`.
- `TIMEOUT`, default 1024: maximum idle cycles a nonzero pending count may wait; ≥ 2.
- `clock` input, 1 bit: single clock; all state is on posedge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `commit_valid` input, 1 bit: `commit_cnt` is meaningful this cycle.
- `commit_cnt` input, `CNT_WIDTH` bits: instructions committed this cycle.
- `flush` input, 1 bit: force emission of any pending count.
- `simv_result` input, 8 bits: deferred software result; nonzero means stop.
- `step` output, `STEP_WIDTH` bits: registered; nonzero for exactly the cycles carrying a batch, 0 otherwise.
- `pending` output, `STEP_WIDTH+1` bits: current accumulator value.
- `halted` output, 1 bit: high in HALT state.
- `halt_code` output, 8 bits: first nonzero `simv_result` sampled.

## Operation
- Accumulator `acc` is `STEP_WIDTH+1` bits wide and cannot overflow.
- `add` = `commit_cnt` when `commit_valid` and state is RUN, else 0.
- `acc_next` = `acc + add`.
- Emit value `e` = min(`acc_next`, `STEP_MAX`). On emission: `step <= e`, `acc <= acc_next - e`, timer cleared. Otherwise: `step <= 0`, `acc <= acc_next`.
- Idle timer: increments each cycle with `acc != 0` and no emission. It is cleared on emission or while `acc == 0`.
- States:
  - RUN (reset state). Emit when any of the following holds and `acc_next != 0`:
    - `acc_next ≥ BATCH`
    - `flush`
    - timer == `TIMEOUT-1`
  - RUN to DRAIN: when `simv_result != 0` is sampled. That cycle's `add` is still counted, `halt_code <= simv_result`, and the emission rule is replaced by "emit if `acc_next != 0`".
  - DRAIN: commits are ignored. Emit every cycle while `acc != 0`. When `acc` reaches 0 after an emission, or is already 0, go to HALT.
  - HALT: `step` = 0, `halted` = 1. Inputs are ignored. The only exit is reset.
- `halt_code` latches only on the RUN-to-DRAIN transition; later `simv_result` changes are ignored.
- If `simv_result != 0` coincides with `flush` or a threshold condition, that is a single emission; there is no double count.
- Saturation: any remainder above `STEP_MAX` stays in `acc`. It is emitted in later cycles: by threshold or timer in RUN, or every cycle in DRAIN.

## Timing
- Reset values, applied asynchronously and immediately: `step`=0, `pending`=0, `halted`=0, `halt_code`=0, state RUN, timer 0.
- Latency: a commit sampled at edge N appears in `step` after edge N, i.e. during cycle N+1, when it causes emission.
- `step` is never nonzero on two consecutive cycles in RUN unless each cycle independently meets an emit condition. It can be nonzero on consecutive cycles in DRAIN.
- Worst-case wait for a pending count in RUN is `TIMEOUT` cycles.
- `halted` rises the cycle after DRAIN empties. If `acc_next` = 0 at detection, it rises one cycle after detection, passing through DRAIN for one cycle.
- A `reset_n` assertion mid-batch discards the pending count; nothing is emitted for it after release.

## Test plan
- Batch threshold (`BATCH`=64, `STEP_WIDTH`=8): `commit_cnt`=4 on 16 consecutive cycles -> `step`=64 for one cycle after the 16th commit edge, then 0; `pending`=0.
- Timeout (`TIMEOUT`=16): one commit of 3, then idle -> `step`=0 for 15 cycles, then `step`=3 for one cycle; timer cleared.
- Saturation (`STEP_WIDTH`=4, `BATCH`=12, `CNT_WIDTH`=4): `acc`=11, then `commit_cnt`=15 -> `step`=15, `pending`=11; after idle, timeout emits 11.
- Flush: `acc`=5, `flush`=1 with `commit_cnt`=2 -> next cycle `step`=7, `pending`=0.
- Halt drain: `acc`=40, `simv_result`=8'h02 with `commit_cnt`=1 -> `step`=41, then `halted`=1, `halt_code`=2. Further commits and `simv_result`=8'h05 -> `step` stays 0 and `halt_code` stays 2.
- Async reset: `acc`=30, timer mid-count, drop `reset_n` between edges -> all outputs 0 immediately; after release with no commits, `step` stays 0 for more than `TIMEOUT` cycles.
